prv_int_src: RTL
================

Name: prv_int_src

Overview:
- Machine-level interrupt source unit that generates the timer, software and external interrupt requests consumed by the privilege exception/interrupt block.
- Holds the 64-bit mtime counter, the mtimecmp compare register and the msip software-interrupt bit, all memory-mapped behind a simple single-word slave port.
- Synchronises the asynchronous external interrupt line.
- Exports mtime for the time/timeh CSRs.

Parameters:
BASE_ADDR, 32'hFFFF_FFE0, base of the 32-byte register window; only bits [31:5] are compared.
PRESCALE, 1, CLK cycles per mtime increment; legal range 1..65535.
SYNC_STAGES, 2, flop stages on ext_irq_in; minimum 2.

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
addr  in  32  slave byte address
ren  in  1  read request
wen  in  1  write request
wdata  in  32  write data, full word only
rdata  out  32  registered read data
ack  out  1  response valid, one cycle after a selected request
err  out  1  error response, qualifies ack
ext_irq_in  in  1  asynchronous external interrupt level
timer_int  out  1  machine timer interrupt pending
timer_prv  out  2  privilege level of timer_int, constant 2'b11 (M)
soft_int  out  1  machine software interrupt pending
soft_prv  out  2  constant 2'b11
ext_int  out  1  synchronised external interrupt pending
ext_prv  out  2  constant 2'b11
mtime_o  out  64  current mtime value

Behaviour:
- Reset (RST high at a CLK edge) sets:
  - mtime = 0, prescale counter = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0.
  - All sync flops = 0.
  - rdata = 0, ack = 0, err = 0, timer_int = 0, soft_int = 0, ext_int = 0.
- Reset mid-transaction drops the pending ack.
- Register map (offset = addr[4:0]):
  - 0x00 mtime[31:0]
  - 0x04 mtime[63:32]
  - 0x08 mtimecmp[31:0]
  - 0x0C mtimecmp[63:32]
  - 0x10 msip (bit 0 RW, other bits read 0)
  - 0x14 ext status (bit 0 = ext_int, read-only; writes ignored, no err)
  - 0x18/0x1C reserved: read 0, write ignored, err = 1.
- Selection: sel = (ren | wen) & (addr[31:5] == BASE_ADDR[31:5]). Unselected requests produce no ack and no state change.
- Handshake: a selected request sampled at edge N gives ack = 1 during cycle N..N+1 only (one-cycle pulse), with rdata/err valid alongside. Back-to-back requests are accepted every cycle; there is no busy/stall.
- Error cases (ack = 1, err = 1, no register update, rdata = 0):
  - addr[1:0] != 0.
  - ren and wen both high.
  - Reserved offset.
- Prescaler:
  - Counter counts 0..PRESCALE-1 and wraps; tick = (count == PRESCALE-1).
  - On tick, mtime increments by 1 with 64-bit wrap (all-ones -> 0).
  - PRESCALE = 1 gives a tick every cycle.
- Write/increment collision:
  - A write to either mtime half in the same cycle as a tick takes priority. The written half takes wdata, the other half holds, and that tick is discarded.
  - The prescaler is unaffected by the write.
- Timer compare:
  - timer_int is a registered version of (mtime >= mtimecmp), unsigned 64-bit, evaluated on register values.
  - Any register change at edge N is reflected in timer_int at edge N+1.
  - Software must handle the non-atomic 32-bit halves.
- Software interrupt: soft_int = msip, taken directly from the register with no extra latency; a write at edge N shows on soft_int after edge N.
- External interrupt:
  - ext_irq_in passes through SYNC_STAGES flops; ext_int = last stage.
  - Level-sensitive; no latching or edge detection.
  - Latency is SYNC_STAGES edges.
- Read-data capture: rdata captures register values as they are before any same-edge tick/write. mtime_o is live mtime.
- The *_prv outputs are constant 2'b11, including during reset.

Test Plan:
- Reset then idle 10 cycles with PRESCALE = 1 -> mtime_o = 10, timer_int = 0, soft_int = 0, ext_int = 0, rdata = 0, ack = 0.
- Write mtimecmp_hi = 0, then mtimecmp_lo = 0x20 -> timer_int rises exactly 1 edge after mtime reaches 0x20. Then write mtimecmp_lo = 0xFFFF_FFFF -> timer_int falls 1 edge after that write.
- Write mtime_lo = 0xFFFF_FFFE and mtime_hi = 0 with PRESCALE = 1 -> after 2 ticks mtime = 0x1_0000_0000 (carry into the high half). Write mtime_lo on a tick cycle -> mtime = wdata exactly, tick discarded.
- PRESCALE = 4 -> mtime increments once every 4 cycles; read of 0x00 gives ack 1 cycle later with the pre-edge value.
- Write 1 to 0x10 -> soft_int = 1 and read returns 0x1. Write 0 -> soft_int = 0. Raise ext_irq_in -> ext_int rises after 2 edges and 0x14 reads 0x1.
- Errors:
  - Access to addr BASE+0x02 -> ack = 1, err = 1, no update.
  - Access to BASE+0x18 -> err = 1.
  - ren & wen together -> err = 1.
  - Address outside the window -> no ack.
  - RST asserted during an ack cycle -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/prv_int_src.sv
// Machine-level interrupt source: mtime / mtimecmp / msip behind a single-word
// slave port, with a synchroniser for the asynchronous external interrupt line.
module prv_int_src #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  input  logic        ext_irq_in,
  output logic        timer_int,
  output logic [1:0]  timer_prv,
  output logic        soft_int,
  output logic [1:0]  soft_prv,
  output logic        ext_int,
  output logic [1:0]  ext_prv,
  output logic [63:0] mtime_o
);

  localparam logic [4:0]  OFF_MTIME_LO = 5'h00;
  localparam logic [4:0]  OFF_MTIME_HI = 5'h04;
  localparam logic [4:0]  OFF_CMP_LO   = 5'h08;
  localparam logic [4:0]  OFF_CMP_HI   = 5'h0C;
  localparam logic [4:0]  OFF_MSIP     = 5'h10;
  localparam logic [4:0]  OFF_EXT      = 5'h14;
  localparam logic [15:0] PRE_TC       = 16'(PRESCALE - 1);

  logic [63:0]            mtime;
  logic [63:0]            mtimecmp;
  logic                   msip;
  logic [15:0]            pre_cnt;
  logic                   tick;
  logic [SYNC_STAGES-1:0] sync_q;

  logic [4:0]  off;
  logic        sel;
  logic        bad_align;
  logic        bad_dir;
  logic        bad_off;
  logic        req_err;
  logic        wr_ok;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_msip;
  logic [31:0] rd_mux;

  // Request decode
  always_comb begin
    off         = addr[4:0];
    sel         = (ren | wen) & (addr[31:5] == BASE_ADDR[31:5]);
    bad_align   = (addr[1:0] != 2'b00);
    bad_dir     = ren & wen;
    bad_off     = (off[4:3] == 2'b11);
    req_err     = bad_align | bad_dir | bad_off;
    wr_ok       = sel & wen & ~req_err;
    wr_mtime_lo = wr_ok & (off == OFF_MTIME_LO);
    wr_mtime_hi = wr_ok & (off == OFF_MTIME_HI);
    wr_cmp_lo   = wr_ok & (off == OFF_CMP_LO);
    wr_cmp_hi   = wr_ok & (off == OFF_CMP_HI);
    wr_msip     = wr_ok & (off == OFF_MSIP);
  end

  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_MTIME_LO: rd_mux = mtime[31:0];
      OFF_MTIME_HI: rd_mux = mtime[63:32];
      OFF_CMP_LO:   rd_mux = mtimecmp[31:0];
      OFF_CMP_HI:   rd_mux = mtimecmp[63:32];
      OFF_MSIP:     rd_mux = {31'h0, msip};
      OFF_EXT:      rd_mux = {31'h0, ext_int};
      default:      rd_mux = 32'h0;
    endcase
  end

  assign tick = (pre_cnt == PRE_TC);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= 16'h0;
    end else if (tick) begin
      pre_cnt <= 16'h0;
    end else begin
      pre_cnt <= pre_cnt + 16'h1;
    end
  end

  // A write to either half wins over a coincident tick; that tick is lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mtime <= 64'h0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= wdata;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'h1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata;
      if (wr_msip)   msip            <= wdata[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_int <= 1'b0;
    end else begin
      timer_int <= (mtime >= mtimecmp);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_in};
    end
  end

  // Response: read data reflects register state before this edge's updates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ack   <= sel;
      err   <= sel & req_err;
      rdata <= (sel & ren & ~req_err) ? rd_mux : 32'h0;
    end
  end

  assign ext_int   = sync_q[SYNC_STAGES-1];
  assign soft_int  = msip;
  assign mtime_o   = mtime;
  assign timer_prv = 2'b11;
  assign soft_prv  = 2'b11;
  assign ext_prv   = 2'b11;

endmodule
